hspi_tx_pattern_src: RTL

//  RAM-side data source for the HSPI TX engine's packet-buffer read port; replaces the fixed

---
 rtl/hspi_tx_pattern_src_if.sv | 27 ++
 rtl/hspi_tx_pattern_src.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hspi_tx_pattern_src_if.sv
// Read-port bundle between the HSPI trigger/TX engine (master) and the pattern source (slave).
`timescale 1ns/1ps
interface hspi_tx_pattern_src_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              tx_act;
    logic [1:0]        mode;
    logic [1:0]        dat_mod;
    logic              ram_csn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic              pkt_done;
    logic [15:0]       seq_num;
    logic              len_err;

    modport master (
        output tx_act, mode, dat_mod, ram_csn, ram_addr,
        input  ram_rdata, busy, pkt_done, seq_num, len_err
    );

    modport slave (
        input  tx_act, mode, dat_mod, ram_csn, ram_addr,
        output ram_rdata, busy, pkt_done, seq_num, len_err
    );
endinterface

// File: rtl/hspi_tx_pattern_src.sv
// Pattern generator behind the HSPI TX packet-buffer read port; ram_rdata is registered, 1 cycle
// after each ram_csn strobe. No backpressure: every strobe is served on the next edge.
`timescale 1ns/1ps
module hspi_tx_pattern_src #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 9,
    parameter int          TX_LEN     = 511,
    parameter logic [15:0] HDR_MAGIC  = 16'hA55A,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001,
    parameter logic [31:0] CONST_WORD = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    hspi_tx_pattern_src_if.slave  hspi
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [ADDR_W:0] CNT_EXP = (ADDR_W+1)'(TX_LEN + 1);

    state_t            state, state_nxt;
    logic              start;
    logic              tx_act_q;
    logic              rise_pend;
    logic [1:0]        mode_q;
    logic [1:0]        dat_mod_q;
    logic [ADDR_W:0]   rd_cnt;
    logic [31:0]       word_cnt;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_nxt;
    logic [31:0]       pat;
    logic [31:0]       pat_m;
    logic [15:0]       seq_num;
    logic              len_err;
    logic [DATA_W-1:0] rdata;
    logic              rise, fall, rd;

    assign rise = hspi.tx_act & ~tx_act_q;
    assign fall = ~hspi.tx_act & tx_act_q;
    assign rd   = ~hspi.ram_csn;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                // a rise seen during DONE is remembered and started here
                if (rise || rise_pend) begin
                    state_nxt = ACTIVE;
                    start     = 1'b1;
                end
            end
            ACTIVE:  if (fall) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);

    always_comb begin
        pat = 32'(hspi.ram_addr);
        if (state == ACTIVE) begin
            case (mode_q)
                2'b01:   pat = (hspi.ram_addr == '0) ? {HDR_MAGIC, seq_num} : word_cnt;
                2'b10:   pat = lfsr;
                2'b11:   pat = CONST_WORD;
                default: pat = 32'(hspi.ram_addr);
            endcase
        end
        case (dat_mod_q)
            2'b00:   pat_m = {24'h0, pat[7:0]};
            2'b01:   pat_m = {16'h0, pat[15:0]};
            default: pat_m = pat;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx_act_q  <= 1'b0;
            rise_pend <= 1'b0;
            mode_q    <= 2'b00;
            dat_mod_q <= 2'b10;
            rd_cnt    <= '0;
            word_cnt  <= '0;
            lfsr      <= LFSR_SEED;
            seq_num   <= '0;
            len_err   <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            tx_act_q  <= hspi.tx_act;
            rise_pend <= (state == DONE) && rise;
            if (start) begin
                mode_q    <= hspi.mode;
                dat_mod_q <= hspi.dat_mod;
            end
            if (start)
                rd_cnt <= '0;
            else if (state == ACTIVE && rd && rd_cnt != '1)
                rd_cnt <= rd_cnt + 1'b1;
            if (rd)
                rdata <= DATA_W'(pat_m);
            if (state == ACTIVE && rd) begin
                if (mode_q == 2'b01 && hspi.ram_addr != '0)
                    word_cnt <= word_cnt + 32'd1;
                if (mode_q == 2'b10)
                    lfsr <= lfsr_nxt;
            end
            // rd_cnt is final here, including a read on the falling-edge cycle
            if (state == DONE) begin
                seq_num <= seq_num + 16'd1;
                if (rd_cnt != CNT_EXP)
                    len_err <= 1'b1;
            end
        end
    end

    assign hspi.ram_rdata = rdata;
    assign hspi.busy      = (state != IDLE);
    assign hspi.pkt_done  = (state == DONE);
    assign hspi.seq_num   = seq_num;
    assign hspi.len_err   = len_err;
endmodule
